// File: rtl/ram_arbiter.sv
// Round-robin arbiter that lets two bus masters share the single-port 32x32 ram.
// A waiting master gets the ram after at most MAX_HOLD cycles of the other master.
module ram_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_din,
   output logic              m0_grant,
   output logic [DATA_W-1:0] m0_dout,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_din,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m1_dout,
   output logic              S_cen,
   output logic              S_wen,
   output logic [ADDR_W-1:0] S_addr,
   output logic [DATA_W-1:0] S_din,
   input  logic [DATA_W-1:0] S_dout
);

   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t            state_r;
   logic              last_r;
   logic [HOLD_W-1:0] hold_cnt_r;

   // Arbitration FSM; last_r remembers the most recent owner for tie-breaking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         last_r     <= 1'b1;
         hold_cnt_r <= {HOLD_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (m0_req && (!m1_req || last_r)) begin
                  state_r    <= GNT0;
                  last_r     <= 1'b0;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else if (m1_req) begin
                  state_r    <= GNT1;
                  last_r     <= 1'b1;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            GNT0: begin
               // Handover happens without an idle bubble, whether by release or hold expiry.
               if (m1_req && (!m0_req || hold_cnt_r == HOLD_LAST)) begin
                  state_r    <= GNT1;
                  last_r     <= 1'b1;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else if (!m0_req) begin
                  state_r <= IDLE;
               end else if (hold_cnt_r != HOLD_LAST) begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end else begin
                  hold_cnt_r <= hold_cnt_r;
               end
            end
            GNT1: begin
               if (m0_req && (!m1_req || hold_cnt_r == HOLD_LAST)) begin
                  state_r    <= GNT0;
                  last_r     <= 1'b0;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else if (!m1_req) begin
                  state_r <= IDLE;
               end else if (hold_cnt_r != HOLD_LAST) begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end else begin
                  hold_cnt_r <= hold_cnt_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               last_r     <= 1'b1;
               hold_cnt_r <= {HOLD_W{1'b0}};
            end
         endcase
      end
   end

   assign m0_grant = (state_r == GNT0);
   assign m1_grant = (state_r == GNT1);

   // Ram pin mux and read-data return; everything idles at zero unless the owner requests.
   always_comb begin
      S_cen   = 1'b0;
      S_wen   = 1'b0;
      S_addr  = {ADDR_W{1'b0}};
      S_din   = {DATA_W{1'b0}};
      m0_dout = {DATA_W{1'b0}};
      m1_dout = {DATA_W{1'b0}};
      case (state_r)
         GNT0: begin
            if (m0_req) begin
               S_cen   = 1'b1;
               S_wen   = m0_wr;
               S_addr  = m0_addr;
               S_din   = m0_din;
               m0_dout = m0_wr ? {DATA_W{1'b0}} : S_dout;
            end else begin
               S_cen = 1'b0;
            end
         end
         GNT1: begin
            if (m1_req) begin
               S_cen   = 1'b1;
               S_wen   = m1_wr;
               S_addr  = m1_addr;
               S_din   = m1_din;
               m1_dout = m1_wr ? {DATA_W{1'b0}} : S_dout;
            end else begin
               S_cen = 1'b0;
            end
         end
         default: begin
            S_cen = 1'b0;
         end
      endcase
   end

endmodule
